ppu_vram_port: RTL and testbench

- CPU-side access controller for PPU video memory: implements the PPUADDR ($2006) / PPUDATA ($2007) programming model and the shared write toggle.
- Queues CPU memory operations and issues them to the PPU memory port only in cycles the renderer does not own the bus; drives the bus ownership select.
- Sits between the CPU register decode and the PPU memory; a sibling of the render fetch pipeline.

---
 rtl/ppu_vram_port_pkg.sv | 27 ++
 rtl/ppu_vram_port_if.sv | 27 ++
 rtl/ppu_vram_port_fifo.sv | 47 ++++
 rtl/ppu_vram_port.sv | 144 ++++++++++++++
 tb/tb_ppu_vram_port.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ppu_vram_port_pkg.sv
// Shared types and constants for the PPU VRAM CPU-access port.
package ppu_pkg;

  localparam int PPU_ADDR_W = 14;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } ppu_state_t;

  typedef struct packed {
    logic                  we;
    logic [PPU_ADDR_W-1:0] addr;
    logic [7:0]            data;
  } ppu_op_t;

  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_SCROLL = 3'd5;
  localparam logic [2:0] REG_ADDR   = 3'd6;
  localparam logic [2:0] REG_DATA   = 3'd7;

  function automatic logic [5:0] vaddr_step(input logic inc32);
    return inc32 ? 6'd32 : 6'd1;
  endfunction

endpackage

// File: rtl/ppu_vram_port_if.sv
// CPU register-access bus and PPU memory bus as seen by ppu_vram_port.
interface ppu_vram_port_if;
  logic        cpu_sel;
  logic        cpu_we;
  logic [2:0]  cpu_reg;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        mem_owner;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport master (
    output cpu_sel, cpu_we, cpu_reg, cpu_wdata,
    input  cpu_rdata,
    input  mem_owner, mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  cpu_sel, cpu_we, cpu_reg, cpu_wdata,
    output cpu_rdata,
    output mem_owner, mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/ppu_vram_port_fifo.sv
// Synchronous FIFO of queued $2007 operations; a push is accepted when full
// if a pop happens in the same cycle.
module ppu_op_fifo
  import ppu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    CLK,
  input  logic    RESET,
  input  logic    push,
  input  ppu_op_t push_op,
  input  logic    pop,
  output ppu_op_t head,
  output logic    full,
  output logic    empty
);

  localparam int PW = $clog2(DEPTH);

  ppu_op_t    slots [DEPTH];
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic        push_ok;
  logic        pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = slots[rd_ptr[PW-1:0]];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers alone define validity.
  always_ff @(posedge CLK) begin
    if (push_ok) slots[wr_ptr[PW-1:0]] <= push_op;
  end

endmodule

// File: rtl/ppu_vram_port.sv
// PPUADDR/PPUDATA programming model with a queued VRAM access port that
// yields to the renderer. Optional macro: PPU_PALETTE_DIRECT_EN.
//
//   state  | meaning
//   IDLE   | bus released to renderer; waiting for a queued op
//   SETUP  | address driven, read strobe off; aborts if renderer claims bus
//   ACCESS | data phase; always completes, pops the op
module ppu_vram_port
  import ppu_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = PPU_ADDR_W
) (
  input  logic             CLK,
  input  logic             RESET,
  ppu_vram_port_if.slave   bus,
  input  logic             inc32,
  input  logic             render_active,
  output logic             w_toggle,
  output logic             busy,
  output logic             ovf
`ifdef PPU_PALETTE_DIRECT_EN
  ,
  output logic [4:0]       pal_addr,
  input  logic [7:0]       pal_rdata
`endif
);

  logic [ADDR_W-1:0] vaddr;
  logic [ADDR_W-1:0] op_addr;
  logic [5:0]        t_hi;
  logic [7:0]        read_buf;
  ppu_state_t        state_q;
  ppu_state_t        state_d;

  ppu_op_t head;
  ppu_op_t push_op;
  logic    fifo_full;
  logic    fifo_empty;
  logic    fifo_pop;
  logic    data_acc;
  logic    push_ok;

  assign data_acc = bus.cpu_sel && (bus.cpu_reg == REG_DATA);
  assign fifo_pop = (state_q == ACCESS);
  assign push_ok  = data_acc && (!fifo_full || fifo_pop);
  assign busy     = !fifo_empty || (state_q != IDLE);

`ifdef PPU_PALETTE_DIRECT_EN
  assign pal_addr = vaddr[4:0];
`endif

  // Palette reads refill the buffer from the nametable mirrored underneath.
  always_comb begin
    op_addr = vaddr;
`ifdef PPU_PALETTE_DIRECT_EN
    if (!bus.cpu_we && (vaddr[13:8] == 6'h3F))
      op_addr = vaddr - ADDR_W'(16'h1000);
`endif
  end

  assign push_op = '{we: bus.cpu_we, addr: PPU_ADDR_W'(op_addr), data: bus.cpu_wdata};

  always_comb begin
    bus.cpu_rdata = 8'h00;
    if (data_acc && !bus.cpu_we) begin
      bus.cpu_rdata = read_buf;
`ifdef PPU_PALETTE_DIRECT_EN
      if (vaddr[13:8] == 6'h3F) bus.cpu_rdata = pal_rdata;
`endif
    end
  end

  ppu_op_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .push    (data_acc),
    .push_op (push_op),
    .pop     (fifo_pop),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      vaddr    <= '0;
      t_hi     <= '0;
      w_toggle <= 1'b0;
      read_buf <= '0;
      ovf      <= 1'b0;
    end else begin
      if (bus.cpu_sel) begin
        case (bus.cpu_reg)
          REG_ADDR: if (bus.cpu_we) begin
            if (!w_toggle) t_hi  <= bus.cpu_wdata[5:0];
            else           vaddr <= ADDR_W'({t_hi, bus.cpu_wdata});
            w_toggle <= ~w_toggle;
          end
          REG_SCROLL: if (bus.cpu_we) w_toggle <= ~w_toggle;
          REG_STATUS: if (!bus.cpu_we) w_toggle <= 1'b0;
          REG_DATA: begin
            if (push_ok) vaddr <= vaddr + ADDR_W'(vaddr_step(inc32));
            else         ovf   <= 1'b1;
          end
          default: ;
        endcase
      end
      if ((state_q == ACCESS) && !head.we) read_buf <= bus.mem_rdata;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.mem_owner = 1'b0;
    bus.mem_addr  = 16'h0000;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = 8'h00;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !render_active) state_d = SETUP;
      end
      SETUP: begin
        bus.mem_owner = 1'b1;
        bus.mem_addr  = 16'(head.addr);
        state_d       = render_active ? IDLE : ACCESS;
      end
      ACCESS: begin
        bus.mem_owner = 1'b1;
        bus.mem_addr  = 16'(head.addr);
        bus.mem_we    = head.we;
        bus.mem_wdata = head.data;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ppu_vram_port.sv
// Directed bench for ppu_vram_port: register table plus multi-cycle sequences.
module tb_ppu_vram_port;
  import ppu_pkg::*;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic inc32 = 1'b0;
  logic render_active = 1'b0;
  logic w_toggle, busy, ovf;

  ppu_vram_port_if bus();

`ifdef PPU_PALETTE_DIRECT_EN
  logic [4:0] pal_addr;
  logic [7:0] pal_rdata = 8'hC3;
`endif

  ppu_vram_port #(.FIFO_DEPTH(2), .ADDR_W(14)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .bus           (bus),
    .inc32         (inc32),
    .render_active (render_active),
    .w_toggle      (w_toggle),
    .busy          (busy),
    .ovf           (ovf)
`ifdef PPU_PALETTE_DIRECT_EN
    ,
    .pal_addr      (pal_addr),
    .pal_rdata     (pal_rdata)
`endif
  );

  always #5 CLK = ~CLK;

  logic [7:0]  tbmem [0:16383];
  logic [13:0] wr_addr_log [$];
  logic [7:0]  wr_data_log [$];

  assign bus.mem_rdata = tbmem[bus.mem_addr[13:0]];

  always @(posedge CLK) begin
    if (bus.mem_owner && bus.mem_we) begin
      tbmem[bus.mem_addr[13:0]] <= bus.mem_wdata;
      wr_addr_log.push_back(bus.mem_addr[13:0]);
      wr_data_log.push_back(bus.mem_wdata);
    end
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cpu_op(input logic we, input logic [2:0] r, input logic [7:0] d,
                        output logic [7:0] rd);
    @(negedge CLK);
    bus.cpu_sel   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_reg   = r;
    bus.cpu_wdata = d;
    #1 rd = bus.cpu_rdata;
    @(posedge CLK);
    #1;
    bus.cpu_sel = 1'b0;
    bus.cpu_we  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    check(name, 16'(done), 16'h0001);
  endtask

  typedef struct {
    logic       we;
    logic [2:0] r;
    logic [7:0] d;
    logic [7:0] exp_rd;
    logic       exp_tog;
  } vec_t;

  vec_t vt [8];

  initial begin : timeout
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rd;
    int n0;

    for (int i = 0; i < 16384; i++) tbmem[i] = 8'h00;
    tbmem[14'h2000] = 8'hAA;
    tbmem[14'h2020] = 8'hBB;
    tbmem[14'h2060] = 8'h5C;
    bus.cpu_sel = 1'b0; bus.cpu_we = 1'b0; bus.cpu_reg = 3'd0; bus.cpu_wdata = 8'h00;

    vt[0] = '{1'b1, REG_ADDR,   8'h21, 8'h00, 1'b1};
    vt[1] = '{1'b0, REG_STATUS, 8'h00, 8'h00, 1'b0};
    vt[2] = '{1'b1, REG_SCROLL, 8'h11, 8'h00, 1'b1};
    vt[3] = '{1'b1, REG_SCROLL, 8'h22, 8'h00, 1'b0};
    vt[4] = '{1'b1, REG_ADDR,   8'h3F, 8'h00, 1'b1};
    vt[5] = '{1'b0, 3'd0,       8'h00, 8'h00, 1'b1};
    vt[6] = '{1'b1, REG_ADDR,   8'h00, 8'h00, 1'b0};
    vt[7] = '{1'b1, 3'd0,       8'hFF, 8'h00, 1'b0};

    // reset state
    #1;
    check("rst w_toggle", 16'(w_toggle), 16'h0);
    check("rst busy", 16'(busy), 16'h0);
    check("rst ovf", 16'(ovf), 16'h0);
    check("rst mem_owner", 16'(bus.mem_owner), 16'h0);
    check("rst mem_addr", bus.mem_addr, 16'h0000);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;

    // register table: toggle behaviour and zero read data
    for (int i = 0; i < 8; i++) begin
      cpu_op(vt[i].we, vt[i].r, vt[i].d, rd);
      check($sformatf("vec%0d rdata", i), 16'(rd), 16'(vt[i].exp_rd));
      check($sformatf("vec%0d toggle", i), 16'(w_toggle), 16'(vt[i].exp_tog));
      check($sformatf("vec%0d busy", i), 16'(busy), 16'h0);
    end
    cpu_op(1'b1, REG_DATA, 8'h3C, rd);
    wait_idle("vaddr3f00 idle");
    check("vaddr 3f00 write", 16'(tbmem[14'h3F00]), 16'h003C);

    // single write: SETUP then ACCESS at 0x2108
    cpu_op(1'b1, REG_ADDR, 8'h21, rd);
    cpu_op(1'b1, REG_ADDR, 8'h08, rd);
    cpu_op(1'b1, REG_DATA, 8'h55, rd);
    @(negedge CLK);
    check("t1 idle owner", 16'(bus.mem_owner), 16'h0);
    @(negedge CLK);
    check("t1 setup owner", 16'(bus.mem_owner), 16'h1);
    check("t1 setup addr", bus.mem_addr, 16'h2108);
    check("t1 setup we", 16'(bus.mem_we), 16'h0);
    @(negedge CLK);
    check("t1 access owner", 16'(bus.mem_owner), 16'h1);
    check("t1 access addr", bus.mem_addr, 16'h2108);
    check("t1 access we", 16'(bus.mem_we), 16'h1);
    check("t1 access wdata", 16'(bus.mem_wdata), 16'h0055);
    @(negedge CLK);
    check("t1 after owner", 16'(bus.mem_owner), 16'h0);
    wait_idle("t1 idle");
    check("t1 mem 2108", 16'(tbmem[14'h2108]), 16'h0055);
    cpu_op(1'b1, REG_DATA, 8'h66, rd);
    wait_idle("t1b idle");
    check("t1 mem 2109", 16'(tbmem[14'h2109]), 16'h0066);

    // buffered reads with inc32
    cpu_op(1'b1, REG_ADDR, 8'h20, rd);
    cpu_op(1'b1, REG_ADDR, 8'h00, rd);
    inc32 = 1'b1;
    cpu_op(1'b0, REG_DATA, 8'h00, rd);
    check("t2 read1", 16'(rd), 16'h0000);
    wait_idle("t2 idle1");
    cpu_op(1'b0, REG_DATA, 8'h00, rd);
    check("t2 read2", 16'(rd), 16'h00AA);
    wait_idle("t2 idle2");
    cpu_op(1'b1, REG_DATA, 8'h77, rd);
    wait_idle("t2 idle3");
    check("t2 vaddr 2040", 16'(tbmem[14'h2040]), 16'h0077);
    inc32 = 1'b0;
    cpu_op(1'b0, REG_DATA, 8'h00, rd);
    check("t2 read3", 16'(rd), 16'h00BB);
    wait_idle("t2 idle4");

    // overflow while renderer owns the bus
    cpu_op(1'b1, REG_ADDR, 8'h22, rd);
    cpu_op(1'b1, REG_ADDR, 8'h00, rd);
    @(negedge CLK);
    render_active = 1'b1;
    check("t3 ovf before", 16'(ovf), 16'h0);
    n0 = wr_addr_log.size();
    cpu_op(1'b1, REG_DATA, 8'h01, rd);
    cpu_op(1'b1, REG_DATA, 8'h02, rd);
    cpu_op(1'b1, REG_DATA, 8'h03, rd);
    check("t3 ovf set", 16'(ovf), 16'h1);
    repeat (4) @(negedge CLK);
    check("t3 owner held", 16'(bus.mem_owner), 16'h0);
    check("t3 busy held", 16'(busy), 16'h1);
    check("t3 no writes", 16'(wr_addr_log.size() - n0), 16'h0);
    render_active = 1'b0;
    wait_idle("t3 idle");
    check("t3 write count", 16'(wr_addr_log.size() - n0), 16'h2);
    if (wr_addr_log.size() >= n0 + 2) begin
      check("t3 w0 addr", 16'(wr_addr_log[n0]), 16'h2200);
      check("t3 w0 data", 16'(wr_data_log[n0]), 16'h0001);
      check("t3 w1 addr", 16'(wr_addr_log[n0+1]), 16'h2201);
      check("t3 w1 data", 16'(wr_data_log[n0+1]), 16'h0002);
    end
    check("t3 dropped", 16'(tbmem[14'h2202]), 16'h0000);
    cpu_op(1'b1, REG_DATA, 8'h04, rd);
    wait_idle("t3b idle");
    check("t3 vaddr+2", 16'(tbmem[14'h2202]), 16'h0004);
    check("t3 ovf sticky", 16'(ovf), 16'h1);

    // renderer claims the bus during SETUP
    cpu_op(1'b1, REG_ADDR, 8'h23, rd);
    cpu_op(1'b1, REG_ADDR, 8'h00, rd);
    n0 = wr_addr_log.size();
    cpu_op(1'b1, REG_DATA, 8'h5A, rd);
    @(negedge CLK);
    check("t4 idle owner", 16'(bus.mem_owner), 16'h0);
    @(negedge CLK);
    check("t4 setup owner", 16'(bus.mem_owner), 16'h1);
    check("t4 setup addr", bus.mem_addr, 16'h2300);
    render_active = 1'b1;
    @(negedge CLK);
    check("t4 abort owner", 16'(bus.mem_owner), 16'h0);
    repeat (3) @(negedge CLK);
    check("t4 no write", 16'(wr_addr_log.size() - n0), 16'h0);
    check("t4 retained", 16'(busy), 16'h1);
    render_active = 1'b0;
    wait_idle("t4 idle");
    check("t4 write count", 16'(wr_addr_log.size() - n0), 16'h1);
    if (wr_addr_log.size() >= n0 + 1) begin
      check("t4 addr", 16'(wr_addr_log[n0]), 16'h2300);
      check("t4 data", 16'(wr_data_log[n0]), 16'h005A);
    end

    // async reset during ACCESS
    cpu_op(1'b1, REG_ADDR, 8'h24, rd);
    cpu_op(1'b1, REG_ADDR, 8'h00, rd);
    cpu_op(1'b1, REG_DATA, 8'h99, rd);
    n0 = wr_addr_log.size();
    cpu_op(1'b1, REG_ADDR, 8'h11, rd);
    @(negedge CLK);
    @(negedge CLK);
    check("t6 access we", 16'(bus.mem_we), 16'h1);
    check("t6 access addr", bus.mem_addr, 16'h2400);
    RESET = 1'b1;
    #1;
    check("t6 w_toggle", 16'(w_toggle), 16'h0);
    check("t6 mem_owner", 16'(bus.mem_owner), 16'h0);
    check("t6 mem_addr", bus.mem_addr, 16'h0000);
    check("t6 mem_we", 16'(bus.mem_we), 16'h0);
    check("t6 mem_wdata", 16'(bus.mem_wdata), 16'h0000);
    check("t6 busy", 16'(busy), 16'h0);
    check("t6 ovf", 16'(ovf), 16'h0);
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    check("t6 no write", 16'(wr_addr_log.size() - n0), 16'h0);
    check("t6 mem 2400", 16'(tbmem[14'h2400]), 16'h0000);
    check("t6 fifo empty", 16'(busy), 16'h0);
    cpu_op(1'b0, REG_DATA, 8'h00, rd);
    check("t6 read_buf cleared", 16'(rd), 16'h0000);
    wait_idle("t6 idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
